// File: rtl/uart_pkg.sv
// Shared types and constants for the UART word receiver.
// Imported by the byte deserialiser and the word assembler.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 217;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte deserialiser: synchroniser, bit timer, FSM, shift register.
// byte_stb/byte_err are single-cycle strobes on the stop-bit sample cycle.
`timescale 1ns/1ps
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_stb,
    output logic       byte_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          s1_q, s2_q;
    logic [1:0]    fill_q;
    logic          armed_q, armed_d;
    logic          rxs;

    assign rxs       = s2_q;
    assign byte_data = shift_q;

    // Synchroniser, fill tracker and FSM state registers.
    // fill_q marks when rxs reflects real line samples rather than
    // reset values, so a low line at reset release never arms the FSM.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
            state_q <= IDLE;
            timer_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            s1_q    <= rx;
            s2_q    <= s1_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_d;
            state_q <= state_d;
            timer_q <= timer_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // Next-state, bit timing and stop-bit strobes.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_stb = 1'b0;
        byte_err = 1'b0;
        armed_d  = armed_q | (fill_q[1] & rxs);
        unique case (state_q)
            IDLE: begin
                if (armed_q && !rxs) begin
                    timer_d = T_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = T_FULL;
                        bit_d   = '0;
                        state_d = DATA;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    shift_d = {rxs, shift_q[7:1]};
                    timer_d = T_FULL;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            STOP: begin
                if (timer_q == '0) begin
                    byte_stb = rxs;
                    byte_err = !rxs;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_word_rx.sv
// UART word receiver: assembles little-endian bytes into words and
// offers them on a valid/ready port with framing/overrun status.
`timescale 1ns/1ps
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [WORD_SIZE-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int LANES = WORD_SIZE / 8;
    localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    logic [7:0]           byte_data;
    logic                 byte_stb;
    logic                 byte_err;

    logic [WORD_SIZE-1:0] asm_q, asm_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 drain;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .byte_data(byte_data),
        .byte_stb (byte_stb),
        .byte_err (byte_err)
    );

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

    // Assembly, output buffer and status registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            asm_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // Lane store, word completion and handshake; a completing word
    // wins over a same-cycle drain so out_valid stays high.
    always_comb begin
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = byte_err;
        drain   = valid_q & out_ready;
        if (drain) begin
            valid_d = 1'b0;
        end
        if (byte_err) begin
            cnt_d = '0;
        end else if (byte_stb) begin
            asm_d[{cnt_q, 3'b000} +: 8] = byte_data;
            if (cnt_q == LAST_LANE) begin
                cnt_d = '0;
                if (!valid_q || drain) begin
                    data_d  = asm_d;
                    valid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

endmodule
